// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - 2R/1W register file with clear sequencer, zero register and pending-write scoreboard
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              ready,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int NREG = 2 ** ADDR_W;
    localparam bit ZR   = (ZERO_REG != 0);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   init_ptr_q, init_ptr_d;
    logic [NREG-1:0]     busy_q, busy_d;
    logic [ADDR_W:0]     busy_cnt_q, busy_cnt_d;

    // Storage has no reset so it can map onto RAM; the INIT sweep clears it.
    logic [DATA_W-1:0]   mem_q [NREG];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    // Qualified traffic: only in RUN, and never to a hardwired-zero register 0.
    logic                run;
    logic                wr_eff;
    logic                iss_eff;

    assign run     = (state_q == ST_RUN);
    assign wr_eff  = run && wr_en    && !(ZR && (wr_addr    == '0));
    assign iss_eff = run && issue_en && !(ZR && (issue_addr == '0));

    function automatic logic [ADDR_W:0] popcnt(input logic [NREG-1:0] v);
        logic [ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < NREG; i++) begin
            c = c + {{ADDR_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Next state of the INIT/RUN sequencer and the clear pointer.
    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        if (state_q == ST_INIT) begin
            init_ptr_d = init_ptr_q + ADDR_W'(1);
            if (init_ptr_q == ADDR_W'(NREG - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    // Scoreboard update: writeback clears, issue sets, so issue wins on a collision.
    always_comb begin
        busy_d = busy_q;
        if (wr_eff) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (iss_eff) begin
            busy_d[issue_addr] = 1'b1;
        end
        busy_cnt_d = popcnt(busy_d);
    end

    // Array write port source: the clear sweep in INIT, writeback in RUN.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (rst_n) begin
            if (state_q == ST_INIT) begin
                mem_we    = 1'b1;
                mem_waddr = init_ptr_q;
                mem_wdata = '0;
            end else if (wr_eff) begin
                mem_we = 1'b1;
            end
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Single write port into the register array.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Read port 1: zero in INIT and for register 0, optional forward of the in-flight write.
    always_comb begin
        rd_data1 = '0;
        rd_busy1 = 1'b0;
        if (run && !(ZR && (rd_addr1 == '0))) begin
            rd_data1 = mem_q[rd_addr1];
            rd_busy1 = busy_q[rd_addr1];
`ifdef REGFILE_BYPASS_EN
            if (wr_eff && (wr_addr == rd_addr1) && !(iss_eff && (issue_addr == rd_addr1))) begin
                rd_data1 = wr_data;
                rd_busy1 = 1'b0;
            end
`endif
        end
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        rd_data2 = '0;
        rd_busy2 = 1'b0;
        if (run && !(ZR && (rd_addr2 == '0))) begin
            rd_data2 = mem_q[rd_addr2];
            rd_busy2 = busy_q[rd_addr2];
`ifdef REGFILE_BYPASS_EN
            if (wr_eff && (wr_addr == rd_addr2) && !(iss_eff && (issue_addr == rd_addr2))) begin
                rd_data2 = wr_data;
                rd_busy2 = 1'b0;
            end
`endif
        end
    end

    assign ready    = run;
    assign busy_cnt = busy_cnt_q;

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised next-generation register file for the single-cycle/multi-cycle datapath.
- Provides 2 combinational read ports and 1 write port, with width and depth set by parameters.
- Adds a post-reset clear sequencer, an optional hardwired-zero register, and a pending-write scoreboard. The control unit uses the scoreboard to detect read-after-write hazards on long-latency producers such as loads and the multiplier.
- Sits between decode (read/issue side) and writeback (write side).

Parameters:
- DATA_W, 32, width of each register in bits.
- ADDR_W, 3, register address width; depth NREG = 2**ADDR_W (default 8).
- ZERO_REG, 1, 1 = register 0 always reads 0, writes and issues to it are dropped; 0 = register 0 is ordinary.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst_n  input  1  reset: synchronous, active-low (sampled on posedge clk).
- rd_addr1  input  ADDR_W  read port 1 address.
- rd_addr2  input  ADDR_W  read port 2 address.
- rd_data1  output  DATA_W  read port 1 data (combinational).
- rd_data2  output  DATA_W  read port 2 data (combinational).
- rd_busy1  output  1  register at rd_addr1 has a pending write.
- rd_busy2  output  1  register at rd_addr2 has a pending write.
- wr_en  input  1  writeback strobe.
- wr_addr  input  ADDR_W  writeback destination.
- wr_data  input  DATA_W  writeback data.
- issue_en  input  1  decode issues an instruction that will later write issue_addr.
- issue_addr  input  ADDR_W  destination of the issued instruction.
- ready  output  1  clear sequence done; the block accepts traffic.
- busy_cnt  output  ADDR_W+1  number of registers currently marked pending.

Behaviour:
- Storage is an NREG x DATA_W array with no per-entry reset, so that it can infer RAM. It is cleared by the sequencer.
- FSM has 2 states, INIT and RUN.
- Reset (rst_n=0 at a posedge):
  - state <= INIT, init_ptr <= 0, busy vector <= 0.
  - ready=0 and busy_cnt=0 the cycle after.
- INIT:
  - Each posedge with rst_n=1 writes 0 to entry init_ptr and increments init_ptr.
  - The posedge that clears entry NREG-1 moves the FSM to RUN.
  - ready goes to 1 exactly NREG cycles after the first posedge with rst_n=1.
  - wr_en and issue_en are ignored in INIT: no array or scoreboard change.
  - rd_data1/2 = 0 and rd_busy1/2 = 0 throughout INIT.
- RUN:
  - wr_en=1 writes wr_data to entry wr_addr at posedge and clears busy[wr_addr].
  - issue_en=1 sets busy[issue_addr] at posedge.
  - If both are active on the same address in the same cycle, set wins: busy stays 1 and data is still written.
  - Reads return array[rd_addr] combinationally.
  - rd_busyN = busy[rd_addrN], subject to bypass (see Optional Feature).
- Writing to a register whose busy bit is 0 is legal: data is written and busy stays 0.
- Issuing to a register that is already busy is legal: busy stays 1.
- With ZERO_REG=1:
  - Address 0 reads 0 and rd_busy is 0.
  - wr_en and issue_en targeting address 0 have no effect.
- busy_cnt equals the population count of the busy vector, registered, updated on the same posedge as the vector. Its range is 0..NREG.
- Reset asserted mid-RUN discards all pending state and restarts INIT; array contents are then re-cleared.
- Reset asserted mid-INIT restarts init_ptr at 0.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: in RUN, if wr_en=1 and wr_addr equals rd_addrN (and is not the dropped register 0), rd_dataN = wr_data and rd_busyN = 0 in that same cycle, unless issue_en targets the same address that cycle. The goal is same-cycle write-then-read visibility.
- Not defined: rd_dataN shows the old value until the posedge, and rd_busyN reflects the current busy bit.

Test Plan:
- Reset clear: fill with nonzero, assert rst_n=0 for 1 cycle -> ready=0 for 8 cycles then 1; every address reads 0; busy_cnt=0.
- Basic write/read: wr_en, wr_addr=5, wr_data=32'hDEADBEEF -> next cycle rd_addr1=5 gives 32'hDEADBEEF; rd_addr2=3 gives 0.
- Scoreboard:
  - issue_addr=2 -> rd_busy1(addr 2)=1 and busy_cnt=1.
  - Then wr_en addr 2 data 7 -> busy clears, busy_cnt=0, reads 7.
  - Same-cycle issue+write to addr 4 -> busy stays 1, data written.
- Zero register (ZERO_REG=1): write 32'h12345678 and issue to addr 0 -> reads 0, rd_busy=0, busy_cnt unchanged.
- INIT traffic: wr_en addr 6 data 9 during INIT cycle 3 -> ignored; addr 6 reads 0 after ready.
- Bypass: with REGFILE_BYPASS_EN, addr 1 busy and wr_en addr 1 data 32'hA5 with rd_addr1=1 -> same cycle rd_data1=32'hA5 and rd_busy1=0. Without the macro, same cycle shows the old value with rd_busy1=1.
